// File: rtl/pixel_column_readout_ctrl_pkg.sv
// rtl/pixel_column_readout_ctrl_pkg.sv - shared defaults, FSM states and word type for the column readout
package hypix_ro_pkg;

  localparam int DEF_N_PIX      = 16;
  localparam int DEF_TOT_W      = 8;
  localparam int DEF_TS_W       = 9;
  localparam int DEF_FTOA_W     = 5;
  localparam int DEF_CLR_CYCLES = 2;
  localparam int DEF_ADDR_W     = $clog2(DEF_N_PIX);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    CLEAR,
    SETTLE
  } ro_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_TOT_W-1:0]  tot;
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_FTOA_W-1:0] ftoa;
  } pix_word_t;

endpackage

// File: rtl/pixel_column_readout_ctrl_if.sv
// rtl/pixel_column_readout_ctrl_if.sv - readout word valid/ready bus between the column sequencer and its consumer
interface pixel_column_readout_ctrl_if #(
  parameter int N_PIX  = 16,
  parameter int TOT_W  = 8,
  parameter int TS_W   = 9,
  parameter int FTOA_W = 5
) ();

  logic                     rd_valid;
  logic                     rd_ready;
  logic [$clog2(N_PIX)-1:0] rd_addr;
  logic [TOT_W-1:0]         rd_tot;
  logic [TS_W-1:0]          rd_ts;
  logic [FTOA_W-1:0]        rd_ftoa;

  modport master (
    output rd_valid,
    output rd_addr,
    output rd_tot,
    output rd_ts,
    output rd_ftoa,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_addr,
    input  rd_tot,
    input  rd_ts,
    input  rd_ftoa,
    output rd_ready
  );

endinterface

// File: rtl/pixel_column_readout_ctrl_rr_arbiter.sv
// rtl/pixel_column_readout_ctrl_rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int  N_PIX = 16,
  localparam int PTR_W = $clog2(N_PIX)
) (
  input  logic [N_PIX-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  logic [PTR_W-1:0] idx;

  // Scan offsets from the top down so the smallest offset from ptr is written last and wins.
  always_comb begin
    grant = ptr;
    idx   = '0;
    for (int i = N_PIX - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pixel_column_readout_ctrl.sv
// rtl/pixel_column_readout_ctrl.sv - column readout sequencer: arbitrate, latch, hand off, clear; optional HYPIX_RO_SKIP_ZERO_TOT_EN
module pixel_column_readout_ctrl
  import hypix_ro_pkg::*;
#(
  parameter int  N_PIX      = DEF_N_PIX,
  parameter int  TOT_W      = DEF_TOT_W,
  parameter int  TS_W       = DEF_TS_W,
  parameter int  FTOA_W     = DEF_FTOA_W,
  parameter int  CLR_CYCLES = DEF_CLR_CYCLES,
  localparam int ADDR_W     = $clog2(N_PIX)
) (
  input  logic                      clk_40MHz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      readout_en,
  input  logic [N_PIX-1:0]          hit_over,
  input  logic [N_PIX*TOT_W-1:0]    pix_tot,
  input  logic [N_PIX*TS_W-1:0]     pix_ts,
  input  logic [N_PIX*FTOA_W-1:0]   pix_ftoa,
  output logic [N_PIX-1:0]          out_flag,
  output logic                      busy,
  pixel_column_readout_ctrl_if.master rd
);

  localparam int              CNT_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLR_CYCLES - 1);

  ro_state_t          state_q, state_d;
  logic [N_PIX-1:0]   hit_q;
  logic [N_PIX-1:0]   served_q, served_d;
  logic [N_PIX-1:0]   flag_q, flag_d;
  logic [N_PIX-1:0]   req;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  grant;
  logic               any_req;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_pend_q, frame_pend_d;
  logic               valid_q, valid_d;
  logic [TOT_W-1:0]   tot_q, tot_d, tot_sel;
  logic [TS_W-1:0]    ts_q, ts_d, ts_sel;
  logic [FTOA_W-1:0]  ftoa_q, ftoa_d, ftoa_sel;
  logic [N_PIX-1:0]   grant_onehot;

  // A frame_start in the arbitration cycle wipes the mask before the grant is chosen.
  assign req = frame_start ? hit_q : (hit_q & ~served_q);

  rr_arbiter #(
    .N_PIX (N_PIX)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  assign tot_sel      = pix_tot[int'(addr_q) * TOT_W +: TOT_W];
  assign ts_sel       = pix_ts[int'(addr_q) * TS_W +: TS_W];
  assign ftoa_sel     = pix_ftoa[int'(addr_q) * FTOA_W +: FTOA_W];
  assign grant_onehot = N_PIX'(1) << addr_q;

  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    frame_pend_d = frame_pend_q;
    valid_d      = valid_q;
    flag_d       = flag_q;
    tot_d        = tot_q;
    ts_d         = ts_q;
    ftoa_d       = ftoa_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          served_d = '0;
        end
        if (readout_en && any_req) begin
          addr_d  = grant;
          state_d = LATCH;
        end
      end

      LATCH: begin
        tot_d  = tot_sel;
        ts_d   = ts_sel;
        ftoa_d = ftoa_sel;
`ifdef HYPIX_RO_SKIP_ZERO_TOT_EN
        if (tot_sel == '0) begin
          flag_d           = grant_onehot;
          served_d[addr_q] = 1'b1;
          cnt_d            = CNT_LOAD;
          state_d          = CLEAR;
        end else begin
          valid_d = 1'b1;
          state_d = SEND;
        end
`else
        valid_d = 1'b1;
        state_d = SEND;
`endif
      end

      SEND: begin
        if (valid_q && rd.rd_ready) begin
          valid_d          = 1'b0;
          flag_d           = grant_onehot;
          served_d[addr_q] = 1'b1;
          cnt_d            = CNT_LOAD;
          state_d          = CLEAR;
        end
      end

      CLEAR: begin
        if (cnt_q == '0) begin
          flag_d  = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SETTLE: begin
        ptr_d   = addr_q + 1'b1;
        state_d = IDLE;
        if (frame_pend_q || frame_start) begin
          served_d     = '0;
          frame_pend_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame boundaries seen mid-transaction are remembered until SETTLE.
    if (frame_start && (state_q inside {LATCH, SEND, CLEAR})) begin
      frame_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      hit_q        <= '0;
      served_q     <= '0;
      flag_q       <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      frame_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      tot_q        <= '0;
      ts_q         <= '0;
      ftoa_q       <= '0;
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_over;
      served_q     <= served_d;
      flag_q       <= flag_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      frame_pend_q <= frame_pend_d;
      valid_q      <= valid_d;
      tot_q        <= tot_d;
      ts_q         <= ts_d;
      ftoa_q       <= ftoa_d;
    end
  end

  assign out_flag    = flag_q;
  assign busy        = (state_q != IDLE);
  assign rd.rd_valid = valid_q;
  assign rd.rd_addr  = addr_q;
  assign rd.rd_tot   = tot_q;
  assign rd.rd_ts    = ts_q;
  assign rd.rd_ftoa  = ftoa_q;

endmodule

// File: tb/tb_pixel_column_readout_ctrl.sv
// tb/tb_pixel_column_readout_ctrl.sv - directed self-checking bench for pixel_column_readout_ctrl
module tb_pixel_column_readout_ctrl;
  import hypix_ro_pkg::*;

  localparam int N = 16;

  logic             clk_40MHz = 1'b0;
  logic             rst;
  logic             frame_start;
  logic             readout_en;
  logic [N-1:0]     hit_over;
  logic [N*8-1:0]   pix_tot;
  logic [N*9-1:0]   pix_ts;
  logic [N*5-1:0]   pix_ftoa;
  logic [N-1:0]     out_flag;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_column_readout_ctrl_if #(.N_PIX(16), .TOT_W(8), .TS_W(9), .FTOA_W(5)) rd_if ();

  pixel_column_readout_ctrl #(
    .N_PIX(16), .TOT_W(8), .TS_W(9), .FTOA_W(5), .CLR_CYCLES(2)
  ) dut (
    .clk_40MHz   (clk_40MHz),
    .rst         (rst),
    .frame_start (frame_start),
    .readout_en  (readout_en),
    .hit_over    (hit_over),
    .pix_tot     (pix_tot),
    .pix_ts      (pix_ts),
    .pix_ftoa    (pix_ftoa),
    .out_flag    (out_flag),
    .busy        (busy),
    .rd          (rd_if)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    hit_over    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_if.rd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check_eq({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic read_word(input string tag, output pix_word_t w);
    wait_valid(tag);
    w.addr = rd_if.rd_addr;
    w.tot  = rd_if.rd_tot;
    w.ts   = rd_if.rd_ts;
    w.ftoa = rd_if.rd_ftoa;
    tick();
  endtask

  task automatic collect(input int cycles, output int nw, output pix_word_t w0,
                         output pix_word_t w1, output logic [N-1:0] flags);
    pix_word_t cur;
    nw = 0; w0 = '0; w1 = '0; flags = '0;
    for (int i = 0; i < cycles; i++) begin
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        cur.addr = rd_if.rd_addr;
        cur.tot  = rd_if.rd_tot;
        cur.ts   = rd_if.rd_ts;
        cur.ftoa = rd_if.rd_ftoa;
        if (nw == 0) w0 = cur;
        else if (nw == 1) w1 = cur;
        nw++;
      end
      flags |= out_flag;
      tick();
    end
  endtask

  initial begin
    pix_word_t w, w0, w1;
    logic [N-1:0] flags;
    int nw, hi_cnt, bad_cnt, stable;
    logic [3:0] rr_exp [3];

    rr_exp[0] = 4'd0; rr_exp[1] = 4'd8; rr_exp[2] = 4'd15;
    for (int i = 0; i < N; i++) begin
      pix_tot[i*8 +: 8]  = 8'h10 + 8'(i);
      pix_ts[i*9 +: 9]   = 9'h100 + 9'(3 * i);
      pix_ftoa[i*5 +: 5] = 5'(i);
    end
    readout_en       = 1'b1;
    rd_if.rd_ready   = 1'b1;

    // reset state
    do_reset();
    check_eq("rst out_flag", 32'(out_flag), 32'h0);
    check_eq("rst rd_valid", 32'(rd_if.rd_valid), 32'h0);
    check_eq("rst busy", 32'(busy), 32'h0);
    check_eq("rst rd_addr", 32'(rd_if.rd_addr), 32'h0);
    check_eq("rst rd_tot", 32'(rd_if.rd_tot), 32'h0);
    check_eq("rst rd_ts", 32'(rd_if.rd_ts), 32'h0);
    check_eq("rst rd_ftoa", 32'(rd_if.rd_ftoa), 32'h0);

    // readout_en low blocks grants
    readout_en = 1'b0;
    hit_over   = 16'h0010;
    collect(20, nw, w0, w1, flags);
    check_eq("en_low words", 32'(nw), 32'd0);
    check_eq("en_low busy", 32'(busy), 32'h0);
    readout_en = 1'b1;

    // single hit on pixel 4
    read_word("single", w);
    check_eq("single addr", 32'(w.addr), 32'd4);
    check_eq("single tot", 32'(w.tot), 32'h14);
    check_eq("single ts", 32'(w.ts), 32'h10C);
    check_eq("single ftoa", 32'(w.ftoa), 32'h04);
    hi_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_flag == 16'h0010) hi_cnt++;
      else if (out_flag != 16'h0000) bad_cnt++;
      tick();
    end
    check_eq("single flag cycles", 32'(hi_cnt), 32'd2);
    check_eq("single flag other", 32'(bad_cnt), 32'd0);
    collect(30, nw, w0, w1, flags);
    check_eq("single no reread", 32'(nw), 32'd0);
    check_eq("single idle busy", 32'(busy), 32'h0);

    // round robin 0, 8, 15 then again after frame_start
    do_reset();
    hit_over = 16'h8101;
    for (int i = 0; i < 3; i++) begin
      read_word("rr1", w);
      check_eq($sformatf("rr1 order %0d", i), 32'(w.addr), 32'(rr_exp[i]));
    end
    collect(20, nw, w0, w1, flags);
    check_eq("rr1 served", 32'(nw), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      read_word("rr2", w);
      check_eq($sformatf("rr2 order %0d", i), 32'(w.addr), 32'(rr_exp[i]));
    end
    check_eq("rr2 pixel15 tot", 32'(w.tot), 32'h1F);
    hit_over = '0;

    // backpressure on pixel 9
    do_reset();
    rd_if.rd_ready = 1'b0;
    hit_over = 16'h0200;
    wait_valid("bp");
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_if.rd_valid && rd_if.rd_addr == 4'd9 && rd_if.rd_tot == 8'h19 &&
          rd_if.rd_ts == 9'h11B && rd_if.rd_ftoa == 5'd9 && out_flag == '0) stable++;
      tick();
    end
    check_eq("bp stable cycles", 32'(stable), 32'd10);
    rd_if.rd_ready = 1'b1;
    tick();
    check_eq("bp flag after hs", 32'(out_flag), 32'h0200);
    check_eq("bp valid after hs", 32'(rd_if.rd_valid), 32'h0);
    hit_over = '0;

    // frame_start during CLEAR of pixel 3
    do_reset();
    hit_over = 16'h0008;
    read_word("fmid1", w);
    check_eq("fmid first addr", 32'(w.addr), 32'd3);
    check_eq("fmid in clear", 32'(out_flag), 32'h0008);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    read_word("fmid2", w);
    check_eq("fmid reread addr", 32'(w.addr), 32'd3);
    collect(30, nw, w0, w1, flags);
    check_eq("fmid once only", 32'(nw), 32'd0);

    // reset during CLEAR of pixel 6
    do_reset();
    hit_over = 16'h0040;
    read_word("rmid1", w);
    check_eq("rmid addr", 32'(w.addr), 32'd6);
    check_eq("rmid flag", 32'(out_flag), 32'h0040);
    rst = 1'b1;
    tick();
    check_eq("rmid out_flag", 32'(out_flag), 32'h0);
    check_eq("rmid rd_valid", 32'(rd_if.rd_valid), 32'h0);
    check_eq("rmid busy", 32'(busy), 32'h0);
    rst = 1'b0;
    read_word("rmid2", w);
    check_eq("rmid served cleared", 32'(w.addr), 32'd6);
    hit_over = '0;

    // zero ToT on pixel 2, ToT 0x3A on pixel 5
    pix_tot[2*8 +: 8] = 8'h00;
    pix_tot[5*8 +: 8] = 8'h3A;
    do_reset();
    hit_over = 16'h0024;
    collect(40, nw, w0, w1, flags);
    check_eq("ztot flags", 32'(flags), 32'h0024);
`ifdef HYPIX_RO_SKIP_ZERO_TOT_EN
    check_eq("ztot words", 32'(nw), 32'd1);
    check_eq("ztot w0 addr", 32'(w0.addr), 32'd5);
    check_eq("ztot w0 tot", 32'(w0.tot), 32'h3A);
`else
    check_eq("ztot words", 32'(nw), 32'd2);
    check_eq("ztot w0 addr", 32'(w0.addr), 32'd2);
    check_eq("ztot w0 tot", 32'(w0.tot), 32'h00);
    check_eq("ztot w1 addr", 32'(w1.addr), 32'd5);
    check_eq("ztot w1 tot", 32'(w1.tot), 32'h3A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_column_readout_ctrl.md
Name: pixel_column_readout_ctrl

Overview:
Readout sequencer for one column of N_PIX pixel cells that hold hit data (ToT, 9-bit timestamp, 5-bit FTOA) behind a level `hit_over` flag.
- Picks one pending pixel per transaction using a round-robin arbiter.
- Latches that pixel's data and presents it downstream with a valid/ready handshake.
- Then pulses that pixel's `out_flag` to clear it.
- A per-frame served mask guarantees each pixel is read at most once per frame. This covers cells that re-raise `hit_over` after clearing.

Parameters:
- N_PIX, 16, number of pixels in the column (power of 2, ≥2).
- TOT_W, 8, ToT width.
- TS_W, 9, timestamp width.
- FTOA_W, 5, FTOA width.
- CLR_CYCLES, 2, number of cycles `out_flag` is held high (≥1).

Ports:
- clk_40MHz, in, 1, readout clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, single-cycle pulse; clears the served mask.
- readout_en, in, 1, arbitration allowed; low during shutter.
- hit_over, in, N_PIX, per-pixel data-ready level.
- pix_tot, in, N_PIX*TOT_W, pixel i ToT at bits [i*TOT_W +: TOT_W].
- pix_ts, in, N_PIX*TS_W, per-pixel timestamp.
- pix_ftoa, in, N_PIX*FTOA_W, per-pixel FTOA.
- out_flag, out, N_PIX, per-pixel clear strobe (registered).
- rd_valid, out, 1, output word valid.
- rd_ready, in, 1, downstream accept.
- rd_addr, out, $clog2(N_PIX), pixel index of the word.
- rd_tot / rd_ts / rd_ftoa, out, TOT_W / TS_W / FTOA_W, latched pixel data.
- busy, out, 1, FSM not in IDLE.

Behaviour:
- Reset (`rst` high at an edge): state IDLE, `out_flag`=0, `rd_valid`=0, all `rd_*` data=0, `rd_addr`=0, `busy`=0, served mask=0, RR pointer=0, clear counter=0.
- `hit_over` is registered once (`hit_q`) before use; it is not compared combinationally. Eligible vector = `hit_q` & ~served.
- IDLE: if `readout_en` and eligible≠0:
  - grant = first eligible index searching upward from the RR pointer, wrapping at N_PIX-1 → 0.
  - latch `rd_addr`=grant; go to LATCH.
- LATCH (1 cycle, lets pixel data settle): capture pix_*[grant] into `rd_tot`/`rd_ts`/`rd_ftoa`; set `rd_valid`=1; go to SEND.
- SEND: hold `rd_valid` and all `rd_*` stable until `rd_valid`&`rd_ready` at an edge.
  - At that edge: `rd_valid`←0; `out_flag[grant]`←1; served[grant]←1; clear counter←CLR_CYCLES-1; go to CLEAR.
- CLEAR: `out_flag[grant]` stays high for exactly CLR_CYCLES cycles, then drops to 0. Go to SETTLE.
  - Only the granted bit is ever high; `out_flag` is one-hot or zero.
- SETTLE (1 cycle): RR pointer ← grant+1 (mod N_PIX); go to IDLE.
  - A new grant therefore occurs no earlier than 2 cycles after `out_flag` falls. This lets the cell's internal clear flag release.
- Minimum transaction with `rd_ready` always high: 1 (IDLE grant) + 1 (LATCH) + 1 (SEND) + CLR_CYCLES + 1 (SETTLE) = 6 cycles at CLR_CYCLES=2.
- `readout_en` dropping mid-transaction: the current transaction completes; only new grants are blocked.
- `frame_start`:
  - In IDLE: served←0 on that edge.
  - In any other state: the clear is deferred and applied at the SETTLE edge. The served bit of the in-flight pixel is also cleared.
- `frame_start` and a grant in the same IDLE cycle: the mask clear wins; the grant is evaluated with served=0.
- `hit_q[grant]` falling during LATCH/SEND: the transaction still completes with the captured data; no abort.
- Reset asserted mid-transaction: immediate return to reset values at that edge. `out_flag` drops and the pending word is discarded.
- `busy`=1 in every state except IDLE.

Optional Feature:
- Macro HYPIX_RO_SKIP_ZERO_TOT_EN.
- Defined: in LATCH, if the captured ToT==0, `rd_valid` stays 0. The FSM goes directly to CLEAR; the pixel is cleared and marked served with no output word.
- Undefined: zero-ToT words are emitted like any other.

Decomposition:
- Package `hypix_ro_pkg`:
  - width constants TOT_W/TS_W/FTOA_W defaults;
  - state enum {IDLE, LATCH, SEND, CLEAR, SETTLE};
  - packed struct `pix_word_t` {addr, tot, ts, ftoa}.
- Sub-module `rr_arbiter` (N_PIX param): inputs req vector and pointer; outputs grant index and any_req; combinational.

Test Plan:
- Single hit: after reset, `hit_over`=16'h0010, `rd_ready`=1 → `rd_addr`=4 with pixel 4 data; `out_flag`=16'h0010 for exactly 2 cycles; no second read of pixel 4 even with `hit_over[4]` still high.
- Round-robin: `hit_over`=16'h8101 held, pointer 0 → order 0, 8, 15; after `frame_start` the next order is 0, 8, 15 again (pointer wrapped to 0).
- Backpressure: `rd_ready`=0 for 10 cycles during SEND → `rd_valid` and data stable for 10 cycles; `out_flag` stays 0 until the handshake edge.
- Frame mid-transaction: `frame_start` pulsed during CLEAR of pixel 3 with `hit_over[3]` still high → pixel 3 is re-read once after SETTLE.
- Reset mid-CLEAR: `rst` high while `out_flag`=16'h0040 → next edge `out_flag`=0, `rd_valid`=0, `busy`=0, served mask cleared.
- With HYPIX_RO_SKIP_ZERO_TOT_EN: pixel 2 ToT=0, pixel 5 ToT=8'h3A → only pixel 5 emitted; `out_flag` pulses on both bits 2 and 5.
